// File: rtl/rf_sync_master.sv
// Register-file sync master: stalls the pipeline, drains it, then reloads the selected GPRs from a snapshot buffer.
// Optional macro RF_SYNC_CNT_EN adds the saturating sync_cnt write counter port.
module rf_sync_master #(
  parameter int SNAP_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             sync_start,
  input  logic [31:0]      sync_mask,
  input  logic             pipe_idle,
  output logic             cpu_stall,
  output logic             busy,
  output logic [4:0]       snap_raddr,
  input  logic [31:0]      snap_rdata,
  output logic             sync_we,
  output logic [4:0]       sync_dst,
  output logic [31:0]      sync_val,
  output logic             sync_done
`ifdef RF_SYNC_CNT_EN
  ,
  output logic [CNT_W-1:0] sync_cnt
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for sync_start
  // S_DRAIN | pipeline stalled, waiting for pipe_idle
  // S_READ  | present lowest pending register to the snapshot buffer
  // S_WRITE | write snapshot data into the RF (one cycle)
  // S_DONE  | one-cycle completion pulse, stall released next cycle

  if (SNAP_LAT != 1) begin : g_bad_snap_lat
    $error("rf_sync_master: only SNAP_LAT == 1 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pend;
  logic [4:0]  dst_q;
  logic [4:0]  raddr_q;
  logic [4:0]  idx;

  // Lowest set bit wins; bit 0 is never set in pend.
  always_comb begin
    idx = '0;
    for (int i = 31; i >= 1; i--) begin
      if (pend[i]) idx = 5'(i);
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sync_start) state_nxt = S_DRAIN;
      S_DRAIN: if (pipe_idle)  state_nxt = (pend != '0) ? S_READ : S_DONE;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = (pend != '0) ? S_READ : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pend    <= '0;
      dst_q   <= '0;
      raddr_q <= '0;
    end else begin
      if (state == S_IDLE && sync_start) pend <= sync_mask & 32'hFFFF_FFFE;
      if (state == S_READ) begin
        pend[idx] <= 1'b0;
        dst_q     <= idx;
        raddr_q   <= idx;
      end
    end
  end

  always_comb begin
    busy       = (state != S_IDLE);
    cpu_stall  = (state != S_IDLE);
    snap_raddr = (state == S_READ) ? idx : raddr_q;
    sync_we    = (state == S_WRITE);
    sync_dst   = (state == S_WRITE) ? dst_q : 5'd0;
    sync_val   = (state == S_WRITE) ? snap_rdata : 32'd0;
    sync_done  = (state == S_DONE);
  end

`ifdef RF_SYNC_CNT_EN
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst)                          sync_cnt <= '0;
    else if (sync_we && sync_cnt != '1)   sync_cnt <= sync_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_rf_sync_master.sv
// Directed scoreboard bench for rf_sync_master; snapshot buffer and RF are modelled here.
module tb_rf_sync_master;

  localparam int CNT_W = 16;

  logic             cpu_clk;
  logic             cpu_rst;
  logic             sync_start;
  logic [31:0]      sync_mask;
  logic             pipe_idle;
  logic             cpu_stall;
  logic             busy;
  logic [4:0]       snap_raddr;
  logic [31:0]      snap_rdata;
  logic             sync_we;
  logic [4:0]       sync_dst;
  logic [31:0]      sync_val;
  logic             sync_done;
`ifdef RF_SYNC_CNT_EN
  logic [CNT_W-1:0] sync_cnt;
`endif

  rf_sync_master #(.SNAP_LAT(1), .CNT_W(CNT_W)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .sync_start (sync_start),
    .sync_mask  (sync_mask),
    .pipe_idle  (pipe_idle),
    .cpu_stall  (cpu_stall),
    .busy       (busy),
    .snap_raddr (snap_raddr),
    .snap_rdata (snap_rdata),
    .sync_we    (sync_we),
    .sync_dst   (sync_dst),
    .sync_val   (sync_val),
    .sync_done  (sync_done)
`ifdef RF_SYNC_CNT_EN
    ,
    .sync_cnt   (sync_cnt)
`endif
  );

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] val;
  } exp_t;

  logic [31:0] snap_mem [32];
  logic [31:0] rf       [32];
  exp_t        exp_q[$];
  int          wcyc_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          writes_seen = 0;
  int          done_cnt = 0;
  int          exp_cnt = 0;
  int          s;
  int          dcyc;
  int          w0;
  int          d0;

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) cyc <= cyc + 1;
  always @(posedge cpu_clk) snap_rdata <= snap_mem[snap_raddr];
  always @(posedge cpu_clk) if (sync_we === 1'b1) rf[sync_dst] <= sync_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed RF write must match the head of the expected queue.
  always @(negedge cpu_clk) begin
    if (sync_done === 1'b1) done_cnt++;
    if (sync_we === 1'b1) begin
      writes_seen++;
      wcyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_dst", {59'd0, sync_dst}, 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("write_dst", {59'd0, sync_dst}, {59'd0, e.dst});
        chk("write_val", {32'd0, sync_val}, {32'd0, e.val});
      end
    end
  end

  task automatic push_mask(input logic [31:0] mask);
    for (int i = 1; i < 32; i++) begin
      if (mask[i]) begin
        exp_q.push_back({5'(i), snap_mem[i]});
        exp_cnt++;
      end
    end
  endtask

  task automatic do_start(input logic [31:0] mask, output int scyc);
    @(negedge cpu_clk);
    sync_start = 1'b1;
    sync_mask  = mask;
    scyc       = cyc;
    @(negedge cpu_clk);
    sync_start = 1'b0;
    sync_mask  = 32'h0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      if (sync_done === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge cpu_clk);
    end
    chk("done_seen", {63'd0, (dc != -1)}, 64'd1);
  endtask

  function automatic logic [63:0] wc(input int k);
    return (wcyc_q.size() > k) ? 64'(wcyc_q[k]) : 64'hFFFF_FFFF;
  endfunction

  initial begin
    cpu_rst    = 1'b1;
    sync_start = 1'b0;
    sync_mask  = 32'h0;
    pipe_idle  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      snap_mem[i] = $urandom;
      rf[i]       = 32'h0;
    end
    snap_mem[1] = 32'hDEAD_BEEF;
    snap_mem[2] = 32'h1234_5678;

    // Reset then idle
    repeat (3) @(negedge cpu_clk);
    chk("reset_outputs", {busy, cpu_stall, sync_we, sync_done, sync_dst, sync_val, snap_raddr}, 64'd0);
    cpu_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge cpu_clk);
      chk("idle_outputs", {busy, cpu_stall, sync_we, sync_done, sync_dst, sync_val, snap_raddr}, 64'd0);
    end
`ifdef RF_SYNC_CNT_EN
    chk("cnt_reset", 64'(sync_cnt), 64'd0);
`endif

    // Basic reload, mask 0x6
    wcyc_q.delete();
    push_mask(32'h0000_0006);
    do_start(32'h0000_0006, s);
    chk("drain_stall", {62'd0, cpu_stall, busy}, 64'd3);
    wait_done(20, dcyc);
    chk("basic_done_cyc", 64'(dcyc), 64'(s + 6));
    chk("basic_stall_in_done", {62'd0, cpu_stall, busy}, 64'd3);
    chk("basic_wr0_cyc", wc(0), 64'(s + 3));
    chk("basic_wr1_cyc", wc(1), 64'(s + 5));
    @(negedge cpu_clk);
    chk("basic_busy_after", {62'd0, cpu_stall, busy}, 64'd0);
    chk("basic_rf1", 64'(rf[1]), 64'h0000_0000_DEAD_BEEF);
    chk("basic_rf2", 64'(rf[2]), 64'h0000_0000_1234_5678);
    chk("basic_q_empty", 64'(exp_q.size()), 64'd0);

    // Drain wait, mask 0x8000_0000
    wcyc_q.delete();
    pipe_idle = 1'b0;
    push_mask(32'h8000_0000);
    do_start(32'h8000_0000, s);
    for (int i = 0; i < 4; i++) begin
      chk("drain_hold", {62'd0, cpu_stall, sync_we}, 64'd2);
      @(negedge cpu_clk);
    end
    pipe_idle = 1'b1;
    wait_done(20, dcyc);
    chk("drain_done_cyc", 64'(dcyc), 64'(s + 8));
    chk("drain_wr_cyc", wc(0), 64'(s + 7));
    chk("drain_rf31", 64'(rf[31]), 64'(snap_mem[31]));

    // Mask 1: nothing to write
    w0 = writes_seen;
    do_start(32'h0000_0001, s);
    wait_done(10, dcyc);
    chk("mask1_done_cyc", 64'(dcyc), 64'(s + 2));
    chk("mask1_no_write", 64'(writes_seen), 64'(w0));

    // All ones: 31 writes ascending
    wcyc_q.delete();
    push_mask(32'hFFFF_FFFF);
    do_start(32'hFFFF_FFFF, s);
    wait_done(100, dcyc);
    chk("all_done_cyc", 64'(dcyc), 64'(s + 64));
    chk("all_wr_count", 64'(wcyc_q.size()), 64'd31);
    chk("all_first_wr", wc(0), 64'(s + 3));
    chk("all_last_wr", wc(30), 64'(s + 63));
`ifdef RF_SYNC_CNT_EN
    chk("cnt_total", 64'(sync_cnt), 64'(exp_cnt));
`endif
    @(negedge cpu_clk);
    chk("all_rf17", 64'(rf[17]), 64'(snap_mem[17]));

    // Start while busy, and start coinciding with DONE
    d0 = done_cnt;
    push_mask(32'h0000_000C);
    do_start(32'h0000_000C, s);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    chk("busy_in_write", {63'd0, sync_we}, 64'd1);
    sync_start = 1'b1;
    sync_mask  = 32'h0000_0010;
    @(negedge cpu_clk);
    sync_start = 1'b0;
    wait_done(20, dcyc);
    chk("busy_done_cyc", 64'(dcyc), 64'(s + 6));
    sync_start = 1'b1;
    sync_mask  = 32'h0000_0002;
    @(negedge cpu_clk);
    sync_start = 1'b0;
    chk("done_start_idle1", {63'd0, busy}, 64'd0);
    @(negedge cpu_clk);
    chk("done_start_idle2", {63'd0, busy}, 64'd0);
    chk("busy_one_done", 64'(done_cnt), 64'(d0 + 1));
    chk("busy_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset during first WRITE of mask 0xF0
    exp_q.push_back({5'd4, snap_mem[4]});
    do_start(32'h0000_00F0, s);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    #1;
    chk("rst_pre_we", {63'd0, sync_we}, 64'd1);
    cpu_rst = 1'b1;
    #1;
    chk("rst_async_drop", {busy, cpu_stall, sync_we, sync_done, sync_dst, sync_val}, 64'd0);
    repeat (3) @(negedge cpu_clk);
    cpu_rst = 1'b0;
    exp_cnt = 0;
`ifdef RF_SYNC_CNT_EN
    chk("cnt_after_rst", 64'(sync_cnt), 64'd0);
`endif
    w0 = writes_seen;
    repeat (10) @(negedge cpu_clk);
    chk("rst_no_resume", 64'(writes_seen), 64'(w0));
    chk("rst_idle", {63'd0, busy}, 64'd0);
    for (int i = 4; i < 8; i++) snap_mem[i] = $urandom;
    push_mask(32'h0000_00F0);
    do_start(32'h0000_00F0, s);
    wait_done(30, dcyc);
    chk("rerun_done_cyc", 64'(dcyc), 64'(s + 10));
    @(negedge cpu_clk);
    chk("rerun_rf4", 64'(rf[4]), 64'(snap_mem[4]));
    chk("rerun_rf7", 64'(rf[7]), 64'(snap_mem[7]));
    chk("rerun_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef RF_SYNC_CNT_EN
    chk("cnt_rerun", 64'(sync_cnt), 64'(exp_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
